// File: rtl/shift_pkg.sv
// Shared constants and types for the shift sequencer/arbiter slice.
package shift_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned AMT_W  = 4;

    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } shift_arb_state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/shift_unit.sv
// Combinational logical shifter: left or right by shift_amount, zero fill.
module shift_unit #(
    parameter int unsigned DATA_W = shift_pkg::DATA_W,
    parameter int unsigned AMT_W  = shift_pkg::AMT_W
) (
    input  logic [AMT_W-1:0]  shift_amount,
    input  logic [DATA_W-1:0] input_data,
    input  logic              LorR,
    output logic [DATA_W-1:0] output_data
);
    import shift_pkg::*;

    always_comb begin
        output_data = input_data;
        if (LorR == SHIFT_RIGHT) begin
            output_data = input_data >> shift_amount;
        end else begin
            output_data = input_data << shift_amount;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one shift_unit between two requesters; IDLE -> EXEC -> RESP sequencing.
// Define SHIFT_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module shift_arbiter #(
    parameter int unsigned DATA_W = shift_pkg::DATA_W,
    parameter int unsigned AMT_W  = shift_pkg::AMT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [AMT_W-1:0]  req0_amount,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_lorr,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [AMT_W-1:0]  req1_amount,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_lorr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              busy
);
    import shift_pkg::*;

    shift_arb_state_t  state;
    logic [AMT_W-1:0]  op_amount;
    logic [DATA_W-1:0] op_data;
    logic              op_lorr;
    logic [DATA_W-1:0] unit_result;
    logic              grant_any;
    req_id_t           grant_id;

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
    req_id_t           last_grant;
`endif

    // Grant selection; a tie goes to whoever was not served last (or to 0 in fixed mode)
    always_comb begin
        grant_any = req0_valid | req1_valid;
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1_valid;
        end
`else
        grant_id = req1_valid & ~req0_valid;
`endif
    end

    assign req0_ready = (state == IDLE) && grant_any && (grant_id == 1'b0);
    assign req1_ready = (state == IDLE) && grant_any && (grant_id == 1'b1);

    shift_unit #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_shift_unit (
        .shift_amount (op_amount),
        .input_data   (op_data),
        .LorR         (op_lorr),
        .output_data  (unit_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_amount <= '0;
            op_data   <= '0;
            op_lorr   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            busy      <= 1'b0;
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_amount <= grant_id ? req1_amount : req0_amount;
                        op_data   <= grant_id ? req1_data   : req0_data;
                        op_lorr   <= grant_id ? req1_lorr   : req0_lorr;
                        rsp_id    <= grant_id;
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
                        last_grant <= grant_id;
`endif
                        busy      <= 1'b1;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= unit_result;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
